mux8_rr_sched: RTL and testbench
================================

# mux8_rr_sched

Round-robin scheduler that shares the 8:1 bit multiplexer datapath among eight requesters. It arbitrates one-hot grants, drives the 3-bit mux select, and forwards the selected source bit downstream under a valid/ready handshake. Each grant holds for a bounded burst of beats so that no source can starve the others. It sits between the eight source ports and the single downstream consumer of the mux output.

## Interface
- `BURST_MAX`, default 8: maximum beats per grant; legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req`  in  8  request per source; the requester holds it high for as long as it has data.
- `i`  in  8  data bit per source; `i[k]` belongs to `req[k]`.
- `ready`  in  1  downstream accepts the current beat.
- `gnt`  out  8  one-hot grant, registered.
- `sel`  out  3  mux select of the granted source, registered.
- `y`  out  1  selected data bit: `i[sel]` when `valid`, else 0.
- `valid`  out  1  beat offered: `(state==XFER) && req[sel]`.
- `busy`  out  1  high in XFER.

## Operation
- **States.** IDLE and XFER. Internal registers:
  - `ptr` (3 b), the round-robin start index.
  - `cnt` (8 b), beats taken in the current burst.
- **IDLE.**
  - `gnt=0`, `valid=0`, `busy=0`.
  - If `req!=0`, pick the first set bit scanning `ptr, ptr+1, ... ptr+7` (mod 8).
  - At the next edge: `sel<=winner`, `gnt<=1<<winner`, `cnt<=0`, go to XFER.
- **XFER.**
  - A beat is `valid && ready`. `cnt` increments on each beat.
  - Leave to IDLE at the edge where either condition holds:
    - (a) `req[sel]==0`;
    - (b) a beat occurs with `cnt==BURST_MAX-1`.
  - On exit: `gnt<=0`, `ptr<=sel+1` (7 wraps to 0). `sel` keeps its value.
- **Stalls.** While `ready=0`, `cnt` holds. There is no timeout; the grant persists while `req[sel]` stays high.
- **Mid-burst request drop.** If `req[sel]` drops mid-burst, `valid` falls in that same cycle (combinational), so no beat occurs, and the block exits at the next edge.
- **Other inputs during XFER.** Changes on non-granted `req` bits are ignored.
- **Reset (asynchronous, any state):**
  - state IDLE; `ptr=0`, `sel=0`, `gnt=0`, `cnt=0`.
  - As a result `valid=0`, `y=0`, `busy=0`, and `gnt` drops immediately.
  - A partial burst is abandoned and no beat is replayed.

## Timing
- `req` rising in cycle N with the block idle gives `gnt`, `sel`, `busy` in cycle N+1.
- `valid` is high in cycle N+1 if `req[sel]` is still high.
- Combinational paths:
  - `y` and `valid` from `req`/`i` (same cycle).
  - No combinational path from `ready` to any output.
- At least one IDLE cycle separates consecutive grants. With `BURST_MAX=B` and continuous `ready`:
  - a burst lasts B cycles plus 1 gap;
  - worst-case wait for a requester is 7·(B+1) cycles after its `req` is sampled in IDLE.
- With `BURST_MAX=1`, every grant is exactly one beat, followed by IDLE.

## Configuration
- `MUX8_SCHED_PRIO_EN` defined:
  - Adds input `prio` (8 b).
  - In IDLE the candidate set is `req&prio` if nonzero, else `req`.
  - Round-robin from `ptr` applies within the chosen set.
  - The `ptr` update rule is unchanged.
- Not defined:
  - The `prio` port is absent.
  - Pure round-robin over `req`.

## Test plan
- **Reset during burst.** Assert `rst_n=0` mid-burst → `gnt=0`, `valid=0`, `y=0`, `sel=0` immediately. After release with `req=8'h10` → `gnt=8'h10`, `sel=4` one cycle later.
- **Round-robin rotation.**
  - Setup: `req=8'hFF` held, `ready=1`, `BURST_MAX=2`.
  - Expected: grants in order 0,1,…,7,0. Each grant gives 2 `valid` cycles, then 1 IDLE cycle.
  - `y` equals `i[sel]` on every beat.
- **Pointer wrap.** `req=8'h81`, start `ptr=0` → grant 0, then 7, then 0.
- **Stall.**
  - Setup: `BURST_MAX=3`, `req=8'h04`, `ready` pattern 1,0,0,1,1.
  - Expected: 3 beats taken over 5 cycles, `cnt` frozen while `ready=0`, exit after the 3rd beat.
- **Early release.**
  - Setup: `req[2]` drops after 1 beat with `BURST_MAX=8`.
  - Expected: `valid=0` in the drop cycle, IDLE next cycle, `ptr=3`. A pending `req[5]` is granted the cycle after that.
- **Priority (`MUX8_SCHED_PRIO_EN` defined).**
  - Setup: `req=8'h0F`, `prio=8'h08`.
  - Expected: grant 3 first, then 3 again while still requesting. Without the macro: grant 0 first.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for an 8:1 bit mux: one-hot grants, bounded bursts, valid/ready output.
// Define MUX8_SCHED_PRIO_EN to add a prio input that narrows the IDLE candidate set.
module mux8_rr_sched #(
    parameter int BURST_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] i,
`ifdef MUX8_SCHED_PRIO_EN
    input  logic [7:0] prio,
`endif
    input  logic       ready,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       y,
    output logic       valid,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [2:0] sel_q,   sel_d;
    logic [7:0] gnt_q,   gnt_d;
    logic [7:0] cnt_q,   cnt_d;

    logic [7:0] cand;
    logic [2:0] winner;
    logic       has_cand;
    logic       beat;

`ifdef MUX8_SCHED_PRIO_EN
    // Prioritised requesters win when any of them is asking; round-robin still applies inside the set.
    assign cand = ((req & prio) != 8'h00) ? (req & prio) : req;
`else
    assign cand = req;
`endif

    // First set candidate scanning ptr, ptr+1, ... ptr+7 with natural 3-bit wrap.
    always_comb begin
        logic [2:0] idx;
        has_cand = 1'b0;
        winner   = ptr_q;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!has_cand && cand[idx]) begin
                has_cand = 1'b1;
                winner   = idx;
            end
        end
    end

    assign valid = (state_q == XFER) && req[sel_q];
    assign y     = valid & i[sel_q];
    assign busy  = (state_q == XFER);
    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign beat  = valid & ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (has_cand) begin
                    state_d = XFER;
                    sel_d   = winner;
                    gnt_d   = 8'h01 << winner;
                    cnt_d   = 8'h00;
                end
            end
            XFER: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    ptr_d   = sel_q + 3'd1;
                end else if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        gnt_d   = 8'h00;
                        ptr_d   = sel_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: vector table plus directed multi-cycle sequences,
// using instances with BURST_MAX = 1, 2, 3 and 8 driven by shared inputs.
module tb_mux8_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;
    logic       ready;
`ifdef MUX8_SCHED_PRIO_EN
    logic [7:0] prio;
`endif

    // Index 0: BURST_MAX=1, 1: BURST_MAX=2, 2: BURST_MAX=3, 3: BURST_MAX=8
    logic [7:0] gnt_w   [4];
    logic [2:0] sel_w   [4];
    logic       y_w     [4];
    logic       valid_w [4];
    logic       busy_w  [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef MUX8_SCHED_PRIO_EN
    mux8_rr_sched #(.BURST_MAX(1)) u_b1 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .prio(prio), .ready(ready),
        .gnt(gnt_w[0]), .sel(sel_w[0]), .y(y_w[0]), .valid(valid_w[0]), .busy(busy_w[0]));
    mux8_rr_sched #(.BURST_MAX(2)) u_b2 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .prio(prio), .ready(ready),
        .gnt(gnt_w[1]), .sel(sel_w[1]), .y(y_w[1]), .valid(valid_w[1]), .busy(busy_w[1]));
    mux8_rr_sched #(.BURST_MAX(3)) u_b3 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .prio(prio), .ready(ready),
        .gnt(gnt_w[2]), .sel(sel_w[2]), .y(y_w[2]), .valid(valid_w[2]), .busy(busy_w[2]));
    mux8_rr_sched #(.BURST_MAX(8)) u_b8 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .prio(prio), .ready(ready),
        .gnt(gnt_w[3]), .sel(sel_w[3]), .y(y_w[3]), .valid(valid_w[3]), .busy(busy_w[3]));
`else
    mux8_rr_sched #(.BURST_MAX(1)) u_b1 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .ready(ready),
        .gnt(gnt_w[0]), .sel(sel_w[0]), .y(y_w[0]), .valid(valid_w[0]), .busy(busy_w[0]));
    mux8_rr_sched #(.BURST_MAX(2)) u_b2 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .ready(ready),
        .gnt(gnt_w[1]), .sel(sel_w[1]), .y(y_w[1]), .valid(valid_w[1]), .busy(busy_w[1]));
    mux8_rr_sched #(.BURST_MAX(3)) u_b3 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .ready(ready),
        .gnt(gnt_w[2]), .sel(sel_w[2]), .y(y_w[2]), .valid(valid_w[2]), .busy(busy_w[2]));
    mux8_rr_sched #(.BURST_MAX(8)) u_b8 (.clk(clk), .rst_n(rst_n), .req(req), .i(i), .ready(ready),
        .gnt(gnt_w[3]), .sel(sel_w[3]), .y(y_w[3]), .valid(valid_w[3]), .busy(busy_w[3]));
`endif

    typedef struct {
        logic [7:0] req;
        logic [7:0] i;
        logic       ready;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       y;
        logic       busy;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input logic [7:0] g, input logic [2:0] s,
                              input logic v, input logic yy, input logic b);
        check({tag, " gnt"},   gnt_w[d],            g);
        check({tag, " sel"},   {5'b0, sel_w[d]},    {5'b0, s});
        check({tag, " valid"}, {7'b0, valid_w[d]},  {7'b0, v});
        check({tag, " y"},     {7'b0, y_w[d]},      {7'b0, yy});
        check({tag, " busy"},  {7'b0, busy_w[d]},   {7'b0, b});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;
        ready = 1'b0;
`ifdef MUX8_SCHED_PRIO_EN
        prio  = 8'h00;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pat(input int c);
        return c[0] ? 8'h5A : 8'hA5;
    endfunction

    initial begin
        logic [7:0] iv;
        int         cyc;
        int         beats;

        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;
        ready = 1'b0;
`ifdef MUX8_SCHED_PRIO_EN
        prio  = 8'h00;
`endif

        // Pointer wrap with req=8'h81 on BURST_MAX=2: grant 0, 7, 0.
        tbl[0] = '{8'h00, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h81, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h81, 8'h80, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h81, 8'h80, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'h81, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h81, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{8'h81, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{8'h81, 8'h80, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{8'h81, 8'h80, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};

        do_reset();
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            req   = tbl[n].req;
            i     = tbl[n].i;
            ready = tbl[n].ready;
            #1;
            expect_out($sformatf("wrap vec%0d", n), 1, tbl[n].gnt, tbl[n].sel,
                       tbl[n].valid, tbl[n].y, tbl[n].busy);
        end

        // Rotation on BURST_MAX=2: grants 0..7,0, two beats each, one IDLE gap.
        do_reset();
        cyc = 0;
        @(negedge clk);
        req = 8'hFF; ready = 1'b1; i = pat(cyc);
        #1;
        expect_out("rot start", 1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 9; g++) begin
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                cyc++;
                i  = pat(cyc);
                iv = i;
                #1;
                expect_out($sformatf("rot g%0d b%0d", g, b), 1, 8'h01 << (g % 8), 3'(g % 8),
                           1'b1, iv[g % 8], 1'b1);
            end
            if (g < 8) begin
                @(negedge clk);
                cyc++;
                i = pat(cyc);
                #1;
                expect_out($sformatf("rot gap%0d", g), 1, 8'h00, 3'(g % 8), 1'b0, 1'b0, 1'b0);
            end
        end

        // BURST_MAX=1: each grant is one beat followed by IDLE.
        do_reset();
        @(negedge clk);
        req = 8'hFF; ready = 1'b1; i = 8'hFF;
        #1;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk); #1;
            expect_out($sformatf("b1 beat%0d", g), 0, 8'h01 << g, 3'(g), 1'b1, 1'b1, 1'b1);
            @(negedge clk); #1;
            expect_out($sformatf("b1 gap%0d", g), 0, 8'h00, 3'(g), 1'b0, 1'b0, 1'b0);
        end

        // Stall on BURST_MAX=3 with ready pattern 1,0,0,1,1.
        do_reset();
        @(negedge clk);
        req = 8'h04; i = 8'h04; ready = 1'b1;
        #1;
        expect_out("stall idle", 2, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        beats = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            #1;
            expect_out($sformatf("stall c%0d", c), 2, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);
            if (valid_w[2] && ready) beats++;
        end
        check("stall beats", 8'(beats), 8'd3);
        @(negedge clk); #1;
        expect_out("stall exit", 2, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("stall regrant", 2, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);

        // Early release on BURST_MAX=8, then reset in the middle of the following burst.
        do_reset();
        @(negedge clk);
        req = 8'h24; i = 8'hFF; ready = 1'b1;
        #1;
        expect_out("early idle", 3, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("early beat", 3, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        req = 8'h20;
        #1;
        expect_out("early drop", 3, 8'h04, 3'd2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        req = 8'h22;
        #1;
        expect_out("early exit", 3, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("early next", 3, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
        @(negedge clk); #1;
        expect_out("pre reset", 3, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_out("async reset", 3, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h10;
        #1;
        expect_out("post reset idle", 3, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("post reset grant", 3, 8'h10, 3'd4, 1'b1, 1'b1, 1'b1);

        // Priority narrowing (or plain round-robin when the feature is absent), BURST_MAX=2.
        do_reset();
        @(negedge clk);
        req = 8'h0F; i = 8'hFF; ready = 1'b1;
`ifdef MUX8_SCHED_PRIO_EN
        prio = 8'h08;
`endif
        #1;
        expect_out("prio idle", 1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
`ifdef MUX8_SCHED_PRIO_EN
        expect_out("prio first", 1, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
`else
        expect_out("prio first", 1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);
`endif
        repeat (2) @(negedge clk);
        @(negedge clk); #1;
`ifdef MUX8_SCHED_PRIO_EN
        expect_out("prio second", 1, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
`else
        expect_out("prio second", 1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
